// File: rtl/expr_pkg.sv
// Shared types and character codes for the streaming infix expression evaluator.
package expr_pkg;

  typedef enum logic [1:0] {
    S_START,
    S_NUM,
    S_CLOSE,
    S_ERR
  } state_t;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_ADD = 8'h2b;
  localparam logic [7:0] CH_MUL = 8'h2a;
  localparam logic [7:0] CH_LP  = 8'h28;
  localparam logic [7:0] CH_RP  = 8'h29;
  localparam logic [7:0] CH_EQ  = 8'h3d;

endpackage

// File: rtl/expr_frame_stack.sv
// Saved {sum, prod} frames for open parentheses; depth counter drives full/empty.
module expr_frame_stack #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  push_sum,
  input  logic [W-1:0]  push_prod,
  output logic [W-1:0]  top_sum,
  output logic [W-1:0]  top_prod,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  sum_mem  [DEPTH];
  logic [W-1:0]  prod_mem [DEPTH];
  logic [DW-1:0] depth_q;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx   = AW'(depth_q);
  assign rd_idx   = AW'(depth_q - DW'(1));
  assign top_sum  = sum_mem[rd_idx];
  assign top_prod = prod_mem[rd_idx];
  assign depth    = depth_q;
  assign full     = (depth_q == DW'(DEPTH));
  assign empty    = (depth_q == '0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      depth_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        sum_mem[i]  <= '0;
        prod_mem[i] <= '0;
      end
    end else if (flush) begin
      depth_q <= '0;
    end else if (push) begin
      sum_mem[wr_idx]  <= push_sum;
      prod_mem[wr_idx] <= push_prod;
      depth_q          <= depth_q + DW'(1);
    end else if (pop) begin
      depth_q <= depth_q - DW'(1);
    end
  end

endmodule

// File: rtl/expr_eval.sv
// Character-serial recogniser/evaluator for "+", "*", parentheses and "=" framing.
module expr_eval #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [7:0]   in,
  input  logic         in_valid,
  output logic         out,
  output logic         done,
  output logic         ok,
  output logic [W-1:0] result
);

  import expr_pkg::*;

  localparam int unsigned DW = $clog2(DEPTH + 1);

  state_t        state_q;
  logic [W-1:0]  sum_q;
  logic [W-1:0]  prod_q;
  logic [W-1:0]  cur_q;
  logic [W-1:0]  term;
  logic [W-1:0]  total;
  logic [W-1:0]  dig_val;
  logic [W-1:0]  cur_next;
  logic [W-1:0]  top_sum;
  logic [W-1:0]  top_prod;
  logic [DW-1:0] depth;
  logic          full;
  logic          empty;
  logic          is_digit;
  logic          push;
  logic          pop;
  logic          flush;

  assign is_digit = (in >= CH_0) && (in <= CH_9);
  assign dig_val  = W'(in[3:0]);
  assign term     = prod_q * cur_q;
  assign total    = sum_q + term;
  assign cur_next = cur_q * W'(10) + dig_val;

  assign push  = in_valid && (state_q == S_START) && (in == CH_LP) && !full;
  assign pop   = in_valid && ((state_q == S_NUM) || (state_q == S_CLOSE)) && (in == CH_RP) && !empty;
  assign flush = in_valid && (in == CH_EQ);

  assign out = ((state_q == S_NUM) || (state_q == S_CLOSE)) && empty;

  expr_frame_stack #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_sum  (sum_q),
    .push_prod (prod_q),
    .top_sum   (top_sum),
    .top_prod  (top_prod),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_START;
      sum_q   <= '0;
      prod_q  <= W'(1);
      cur_q   <= '0;
      done    <= 1'b0;
      ok      <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (in_valid) begin
        if (in == CH_EQ) begin
          // "=" always closes the frame, whatever state it arrives in
          done    <= 1'b1;
          state_q <= S_START;
          sum_q   <= '0;
          prod_q  <= W'(1);
          cur_q   <= '0;
          if (((state_q == S_NUM) || (state_q == S_CLOSE)) && empty) begin
            ok     <= 1'b1;
            result <= total;
          end else begin
            ok <= 1'b0;
          end
        end else begin
          unique case (state_q)
            S_START: begin
              if (is_digit) begin
                cur_q   <= dig_val;
                state_q <= S_NUM;
              end else if ((in == CH_LP) && !full) begin
                sum_q  <= '0;
                prod_q <= W'(1);
              end else begin
                state_q <= S_ERR;
              end
            end
            S_NUM, S_CLOSE: begin
              if (is_digit && (state_q == S_NUM)) begin
                cur_q <= cur_next;
              end else if (in == CH_ADD) begin
                sum_q   <= total;
                prod_q  <= W'(1);
                state_q <= S_START;
              end else if (in == CH_MUL) begin
                prod_q  <= term;
                state_q <= S_START;
              end else if ((in == CH_RP) && !empty) begin
                // Parenthesised value becomes the operand of the enclosing level
                cur_q   <= total;
                sum_q   <= top_sum;
                prod_q  <= top_prod;
                state_q <= S_CLOSE;
              end else begin
                state_q <= S_ERR;
              end
            end
            S_ERR: begin
            end
            default: state_q <= S_ERR;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// Randomised bench for expr_eval against a tokenise / shunting-yard / RPN reference model.
module tb_expr_eval;

  localparam int unsigned TW = 8;
  localparam int unsigned TD = 4;
  localparam longint MASK = (longint'(1) << TW) - 1;

  localparam int K_NUM = 0;
  localparam int K_ADD = 1;
  localparam int K_MUL = 2;
  localparam int K_LP  = 3;
  localparam int K_RP  = 4;

  typedef struct {
    int     kind;
    longint val;
  } tok_t;

  logic          clk = 1'b0;
  logic          clr;
  logic [7:0]    in;
  logic          in_valid;
  logic          out;
  logic          done;
  logic          ok;
  logic [TW-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  byte           seg[$];
  logic [TW-1:0] m_result;
  bit            m_ok;
  bit            m_out;

  always #5 clk = ~clk;

  expr_eval #(
    .W     (TW),
    .DEPTH (TD)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .in       (in),
    .in_valid (in_valid),
    .out      (out),
    .done     (done),
    .ok       (ok),
    .result   (result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int prec(input int kind);
    return (kind == K_MUL) ? 2 : 1;
  endfunction

  // Whole-string judgement: token grammar + nesting limit, then infix -> RPN -> value.
  function automatic void analyse(input byte s[$], output bit valid, output logic [TW-1:0] val);
    tok_t   toks[$];
    tok_t   ops[$];
    tok_t   rpn[$];
    longint st[$];
    tok_t   t;
    int     depth = 0;
    bit     expect_opnd = 1'b1;
    bit     prev_digit = 1'b0;
    logic [7:0] c;
    longint a;
    longint b;
    valid = (s.size() != 0);
    val   = '0;
    foreach (s[i]) begin
      c = s[i];
      if (c >= 8'h30 && c <= 8'h39) begin
        if (prev_digit) begin
          t = toks.pop_back();
          t.val = (t.val * 10 + longint'(c - 8'h30)) & MASK;
          toks.push_back(t);
        end else if (!expect_opnd) begin
          valid = 1'b0;
        end else begin
          t.kind = K_NUM;
          t.val  = longint'(c - 8'h30);
          toks.push_back(t);
          expect_opnd = 1'b0;
          prev_digit  = 1'b1;
        end
      end else begin
        prev_digit = 1'b0;
        t.val = 0;
        if (c == 8'h2b || c == 8'h2a) begin
          if (expect_opnd) valid = 1'b0;
          t.kind = (c == 8'h2b) ? K_ADD : K_MUL;
          toks.push_back(t);
          expect_opnd = 1'b1;
        end else if (c == 8'h28) begin
          if (!expect_opnd) valid = 1'b0;
          depth++;
          if (depth > int'(TD)) valid = 1'b0;
          t.kind = K_LP;
          toks.push_back(t);
        end else if (c == 8'h29) begin
          if (expect_opnd || depth == 0) valid = 1'b0;
          depth--;
          t.kind = K_RP;
          toks.push_back(t);
        end else begin
          valid = 1'b0;
        end
      end
    end
    if (expect_opnd || depth != 0) valid = 1'b0;
    if (!valid) return;
    foreach (toks[i]) begin
      t = toks[i];
      if (t.kind == K_NUM) begin
        rpn.push_back(t);
      end else if (t.kind == K_LP) begin
        ops.push_back(t);
      end else if (t.kind == K_RP) begin
        while (ops[$].kind != K_LP) rpn.push_back(ops.pop_back());
        void'(ops.pop_back());
      end else begin
        while (ops.size() > 0 && ops[$].kind != K_LP && prec(ops[$].kind) >= prec(t.kind))
          rpn.push_back(ops.pop_back());
        ops.push_back(t);
      end
    end
    while (ops.size() > 0) rpn.push_back(ops.pop_back());
    foreach (rpn[i]) begin
      if (rpn[i].kind == K_NUM) begin
        st.push_back(rpn[i].val);
      end else begin
        b = st.pop_back();
        a = st.pop_back();
        st.push_back(((rpn[i].kind == K_ADD) ? (a + b) : (a * b)) & MASK);
      end
    end
    val = TW'(st[0]);
  endfunction

  task automatic send(input byte c);
    bit            v;
    logic [TW-1:0] val;
    @(negedge clk);
    in       = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (c == "=") begin
      analyse(seg, v, val);
      seg.delete();
      if (v) m_result = val;
      m_ok  = v;
      m_out = 1'b0;
      check_eq("done_on_eq", done, 1);
      check_eq("ok", ok, m_ok);
    end else begin
      seg.push_back(c);
      analyse(seg, v, val);
      m_out = v;
      check_eq("done_idle", done, 0);
    end
    check_eq("out", out, m_out);
    check_eq("result", result, m_result);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in       = 8'($urandom);
    @(posedge clk);
    #1;
    check_eq("gap_out", out, m_out);
    check_eq("gap_done", done, 0);
    check_eq("gap_result", result, m_result);
  endtask

  // gap_mode 0: back-to-back, 1: idle before every char, 2: random idles
  task automatic send_str(input string s, input int gap_mode);
    for (int i = 0; i < s.len(); i++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) idle();
      send(s[i]);
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b1;
    #1;
    seg.delete();
    m_result = '0;
    m_ok     = 1'b0;
    m_out    = 1'b0;
    check_eq("clr_out", out, 0);
    check_eq("clr_done", done, 0);
    check_eq("clr_ok", ok, 0);
    check_eq("clr_result", result, 0);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic gen_expr(output byte q[$]);
    int  depth = 0;
    bit  need = 1'b1;
    int  len = 0;
    int  r;
    byte cs [9] = '{8'h30, 8'h35, 8'h2b, 8'h2a, 8'h28, 8'h29, 8'h3d, 8'h78, 8'h20};
    q.delete();
    while (1) begin
      if (need) begin
        if (len < 16 && depth <= int'(TD) && $urandom_range(0, 3) == 0) begin
          q.push_back(8'h28);
          depth++;
        end else begin
          r = $urandom_range(1, 3);
          for (int k = 0; k < r; k++) q.push_back(byte'(8'h30 + $urandom_range(0, 9)));
          need = 1'b0;
        end
      end else begin
        r = $urandom_range(0, 9);
        if (len >= 16 || r < 3) begin
          if (depth > 0) begin
            q.push_back(8'h29);
            depth--;
          end else begin
            break;
          end
        end else if (r < 5 && depth > 0) begin
          q.push_back(8'h29);
          depth--;
        end else begin
          q.push_back((r % 2 == 1) ? 8'h2b : 8'h2a);
          need = 1'b1;
        end
      end
      len++;
    end
    if ($urandom_range(0, 5) == 0) q[$urandom_range(0, q.size() - 1)] = cs[$urandom_range(0, 8)];
    q.push_back(8'h3d);
  endtask

  initial begin
    byte q[$];
    clr      = 1'b1;
    in_valid = 1'b0;
    in       = '0;
    m_result = '0;
    m_ok     = 1'b0;
    m_out    = 1'b0;
    #12;
    check_eq("rst_out", out, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ok", ok, 0);
    check_eq("rst_result", result, 0);
    @(negedge clk);
    clr = 1'b0;

    send_str("12+3*4=", 0);
    check_eq("r_12+3*4", result, 24);
    send_str("(1+2)*(3+4)=", 0);
    check_eq("r_parens", result, 21);
    send_str("((((5))))=", 0);
    check_eq("r_depth4", result, 5);
    send_str("(((((5)))))=", 0);
    check_eq("ok_overflow", ok, 0);
    send_str("3+*4=", 0);
    send_str("7=", 0);
    check_eq("r_recover", result, 7);
    send_str("16*16+3=", 0);
    check_eq("r_wrap_mul", result, 3);
    send_str("300=", 0);
    check_eq("r_wrap_num", result, 44);
    send_str("9*9=", 1);
    check_eq("r_toggle", result, 81);
    send_str("9*", 1);
    do_clr();
    send_str("2=", 0);
    check_eq("r_after_clr", result, 2);
    send_str(")1=", 0);
    send_str("(1=", 0);
    send_str("=", 0);
    send_str("==", 0);

    for (int n = 0; n < 300; n++) begin
      gen_expr(q);
      foreach (q[i]) begin
        if ($urandom_range(0, 3) == 0) idle();
        send(q[i]);
      end
      if ($urandom_range(0, 49) == 0) do_clr();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
